// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: a main output slot plus a skid slot, sequenced by a 3-state FSM.
// Handshake outputs decode from registered state only, so there is no ready/valid combinational path.
module pipe_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aH,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] main_r, main_s;
  logic [WIDTH-1:0] skid_r, skid_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_ready   = (state_r != FULL);
  assign out_valid  = (state_r != EMPTY);
  assign out_data   = main_r;
  assign count      = state_r;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Next-state and slot update; flush wins over every other event.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_s  = in_data;
            state_s = ONE;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_s  = in_data;
            state_s = ONE;
          end else if (in_fire_s) begin
            skid_s  = in_data;
            state_s = FULL;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          // in_ready is low here, so only the pop can happen.
          if (out_ready) begin
            main_s  = skid_r;
            state_s = ONE;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State and slot registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_r <= EMPTY;
      main_r  <= {WIDTH{1'b0}};
      skid_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
    end
  end

endmodule
